crc_decoder: RTL and testbench

- Bit-serial CRC checker; the receive-side counterpart of the CRC encoder.
- Accepts a codeword (DATAWIDTH data bits followed by CRCWIDTH check bits) and a generator polynomial.
- Divides the codeword by the polynomial, one bit per clock, and reports the remainder (syndrome) plus an error flag.
- Sits on the receive path directly after codeword capture and shares the encoder's genPoly convention.

---
 rtl/crc_decoder.sv | 102 ++++++++++
 tb/tb_crc_decoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/crc_decoder.sv
// Bit-serial CRC checker: divides {data,crc} by the generator, one bit per clock.
// Reports the remainder as the syndrome along with an error flag and a done pulse.
module crc_decoder #(
    parameter int DATAWIDTH = 8,
    parameter int CRCWIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ctrlen,
    input  logic [DATAWIDTH-1:0] datain,
    input  logic [CRCWIDTH-1:0]  crcin,
    input  logic [CRCWIDTH:0]    genPoly,
    output logic [CRCWIDTH-1:0]  syndrome,
    output logic                 crcerror,
    output logic                 crcready,
    output logic                 busy
);

    localparam int N    = DATAWIDTH + CRCWIDTH;
    localparam int CNTW = $clog2(N);
    localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state_q;
    logic [N-1:0]        shreg_q;
    logic [CRCWIDTH-1:0] rem_q;
    logic [CRCWIDTH-1:0] rem_d;
    logic [CRCWIDTH-1:0] poly_q;
    logic [CNTW-1:0]     cnt_q;
    logic [CRCWIDTH-1:0] syndrome_q;
    logic                crcerror_q;
    logic                crcready_q;
    logic                busy_q;

    // The x^n term of the generator is implicit in the shift-out of rem MSB.
    logic unused_polytop;
    assign unused_polytop = genPoly[CRCWIDTH];

    always_comb begin
        rem_d = {rem_q[CRCWIDTH-2:0], shreg_q[N-1]};
        if (rem_q[CRCWIDTH-1]) begin
            rem_d = rem_d ^ poly_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            rem_q      <= '0;
            poly_q     <= '0;
            cnt_q      <= '0;
            syndrome_q <= '0;
            crcerror_q <= 1'b0;
            crcready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            crcready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ctrlen) begin
                        shreg_q <= {datain, crcin};
                        poly_q  <= genPoly[CRCWIDTH-1:0];
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    rem_q   <= rem_d;
                    shreg_q <= {shreg_q[N-2:0], 1'b0};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        syndrome_q <= rem_d;
                        crcerror_q <= |rem_d;
                        crcready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign syndrome = syndrome_q;
    assign crcerror = crcerror_q;
    assign crcready = crcready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_crc_decoder.sv
// Self-checking bench for crc_decoder: directed plan cases plus random codewords
// checked against a polynomial long-division model.
module tb_crc_decoder;

    localparam int DW = 8;
    localparam int CW = 4;
    localparam int N  = DW + CW;

    logic          clk;
    logic          resetn;
    logic          ctrlen;
    logic [DW-1:0] datain;
    logic [CW-1:0] crcin;
    logic [CW:0]   genPoly;
    logic [CW-1:0] syndrome;
    logic          crcerror;
    logic          crcready;
    logic          busy;

    int passed = 0;
    int total  = 0;
    logic [CW-1:0] prev_syn;
    logic          prev_err;

    crc_decoder #(.DATAWIDTH(DW), .CRCWIDTH(CW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .ctrlen   (ctrlen),
        .datain   (datain),
        .crcin    (crcin),
        .genPoly  (genPoly),
        .syndrome (syndrome),
        .crcerror (crcerror),
        .crcready (crcready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Codeword polynomial modulo the full generator (leading x^CW forced to 1).
    function automatic logic [CW-1:0] model_rem(input logic [DW-1:0] d,
                                               input logic [CW-1:0] c,
                                               input logic [CW:0] gp);
        logic [N-1:0] v;
        logic [CW:0]  g;
        v = {d, c};
        g = {1'b1, gp[CW-1:0]};
        for (int i = N - 1; i >= CW; i--) begin
            if (v[i]) v[i -: CW + 1] = v[i -: CW + 1] ^ g;
        end
        return v[CW-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run(input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic [CW:0] gp, input bit strobe,
                       input int abort_at, input string tag);
        logic [CW-1:0] exp;
        int i, busy_n, rdy_n;
        exp = model_rem(d, c, gp);
        datain  = d;
        crcin   = c;
        genPoly = gp;
        ctrlen  = 1'b1;
        @(negedge clk);
        ctrlen  = 1'b0;
        datain  = DW'($urandom);
        crcin   = CW'($urandom);
        genPoly = (CW+1)'($urandom);
        check({tag, " hold_syn"}, 32'(syndrome), 32'(prev_syn));
        check({tag, " hold_err"}, 32'(crcerror), 32'(prev_err));
        i = 0;
        busy_n = 0;
        while (!crcready && i < 3 * N) begin
            if (busy) busy_n++;
            if (strobe && i == 3) begin
                ctrlen = 1'b1;
                datain = '1;
            end
            if (strobe && i == 4) ctrlen = 1'b0;
            if (i == abort_at) begin
                resetn = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
                check({tag, " rst_syn"}, 32'(syndrome), 0);
                check({tag, " rst_err"}, 32'(crcerror), 0);
                check({tag, " rst_rdy"}, 32'(crcready), 0);
                check({tag, " rst_busy"}, 32'(busy), 0);
                rdy_n = 0;
                repeat (N + 3) begin
                    @(negedge clk);
                    rdy_n += int'(crcready);
                end
                check({tag, " no_rdy"}, 32'(rdy_n), 0);
                prev_syn = '0;
                prev_err = 1'b0;
                return;
            end
            @(negedge clk);
            i++;
        end
        check({tag, " latency"}, 32'(i), 32'(N));
        check({tag, " busy_n"}, 32'(busy_n), 32'(N));
        check({tag, " syn"}, 32'(syndrome), 32'(exp));
        check({tag, " err"}, 32'(crcerror), 32'(exp != '0));
        @(negedge clk);
        check({tag, " pulse"}, 32'(crcready), 0);
        rdy_n = 0;
        repeat (N + 2) begin
            @(negedge clk);
            rdy_n += int'(crcready);
        end
        check({tag, " extra_rdy"}, 32'(rdy_n), 0);
        check({tag, " keep_syn"}, 32'(syndrome), 32'(exp));
        prev_syn = exp;
        prev_err = (exp != '0);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic [CW-1:0] rc;
        logic [CW:0]   rg;
        resetn  = 1'b0;
        ctrlen  = 1'b0;
        datain  = '0;
        crcin   = '0;
        genPoly = 5'b10011;
        prev_syn = '0;
        prev_err = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        check("reset syn", 32'(syndrome), 0);
        check("reset err", 32'(crcerror), 0);
        check("reset rdy", 32'(crcready), 0);
        check("reset busy", 32'(busy), 0);
        @(negedge clk);

        check("plan1 model", 32'(model_rem(8'h01, 4'h3, 5'b10011)), 0);
        run(8'h01, 4'h3, 5'b10011, 1'b0, -1, "valid01");
        run(8'h80, 4'hE, 5'b10011, 1'b0, -1, "valid80");
        check("plan3 model", 32'(model_rem(8'h01, 4'h2, 5'b10011)), 1);
        run(8'h01, 4'h2, 5'b10011, 1'b0, -1, "crcbit");
        check("plan4 model", 32'(model_rem(8'h00, 4'h3, 5'b10011)), 3);
        run(8'h00, 4'h3, 5'b10011, 1'b0, -1, "databit");
        run(8'h01, 4'h3, 5'b10011, 1'b1, -1, "strobe");
        run(8'h01, 4'h3, 5'b10011, 1'b0, 5, "abort");
        run(8'h01, 4'h2, 5'b10011, 1'b0, -1, "restart");
        run(8'hA7, 4'h9, 5'b10000, 1'b0, -1, "poly0");
        run(8'h00, 4'h0, 5'b10011, 1'b0, -1, "allzero");

        for (int k = 0; k < 12; k++) begin
            rd = DW'($urandom);
            rg = (CW+1)'($urandom);
            rc = CW'($urandom);
            if (k[0]) rc = model_rem(rd, '0, rg);
            run(rd, rc, rg, k[1], -1, "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
